io_arbiter: RTL and testbench
=============================

# io_arbiter

Two-requester arbiter and sequencer for the 6530 I/O register port (port A/B data and DDR registers at offsets 0–3). It sits between the CPU bus-interface logic and a host/debug bridge, and serialises their accesses into single-cycle `enable` strobes on the I/O block. It returns read data once the I/O block's registered `DO`/`OE` has settled. It owns arbitration, command latching and the read-capture timing, so neither requester needs to know the I/O block's one-cycle read latency.

## Interface
- `RR`, default 1: 1 = round-robin arbitration; 0 = fixed priority, requester 0 always wins.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req[1:0]` input 2: per-requester request; held high until that requester's `ack` pulse.
- `req_we_n[1:0]` input 2: per-requester direction; 0 = write, 1 = read.
- `req_addr0`, `req_addr1` input 3 each: register offset for each requester.
- `req_wdata0`, `req_wdata1` input 8 each: write data for each requester.
- `ack[1:0]` output 2: one-cycle completion pulse, at most one bit set.
- `rdata` output 8: read result, valid while `ack` is non-zero.
- `rerr` output 1: read hit an unmapped offset; valid with `ack`.
- `io_enable` output 1: drives the I/O block `enable`.
- `io_we_n` output 1: drives the I/O block `we_n`.
- `io_addr` output 3: drives the I/O block `A`.
- `io_wdata` output 8: drives the I/O block `DI`.
- `io_rdata` input 8: from the I/O block `DO`.
- `io_oe` input 1: from the I/O block `OE`.

## Operation
- The FSM has three states: IDLE, ISSUE and RESP. One transaction takes exactly 3 cycles; peak rate is 1 access per 3 clocks.
- **IDLE**
  - If any `req` bit is set, choose a winner.
  - Latch the winner's we_n, addr and wdata into command registers, record the grant index, then go to ISSUE.
  - If no request is pending, stay in IDLE.
- **ISSUE**
  - `io_enable`=1 and `io_we_n`/`io_addr`/`io_wdata` come from the command registers; all of these are registered outputs.
  - The I/O block samples them at the end of this cycle. Go to RESP.
- **RESP**
  - `io_enable`=0. Assert `ack[grant]`=1 for this cycle only.
  - Read with `io_oe`=1: `rdata`=`io_rdata`, `rerr`=0.
  - Read with `io_oe`=0 (offsets 4–7): `rdata`=8'hFF, `rerr`=1.
  - Write: `rdata`=8'h00, `rerr`=0; unmapped write offsets are still issued, and the I/O block ignores them.
  - Go to IDLE.
- **Arbitration with RR=1**
  - On simultaneous requests, the requester not granted last wins.
  - `last_grant` updates only at grant time.
- **Arbitration with RR=0**
  - Requester 0 always wins, and requester 1 can starve.
- A requester deasserts `req` in the cycle after its `ack`. In the IDLE cycle that follows, its `req` is either low or is a new request.
- A `req` dropped before `ack` is a protocol violation. The latched command still completes and `ack` still pulses.
- Request inputs are ignored outside IDLE. Changing the address or data fields after grant has no effect.

## Timing
- Reset values:
  - state=IDLE
  - `ack`=0, `rdata`=0, `rerr`=0
  - `io_enable`=0, `io_we_n`=1, `io_addr`=0, `io_wdata`=0
  - `last_grant`=1, so requester 0 wins the first tie.
- Latency is measured from the edge where `req` is first sampled high in IDLE: `io_enable` is high in the next cycle, and `ack` is high in the cycle after that, i.e. request-to-ack = 2 edges.
- `io_enable` is never high in two consecutive cycles, and there is at least a 2-cycle gap between strobes.
- Reset asserted in ISSUE or RESP aborts immediately: `io_enable` goes to 0, no `ack` is produced, and the transaction is lost. A write may already have landed if reset arrives after the ISSUE edge.
- Reset release: the first grant can occur on the first rising edge after `rst_n` goes high.

## Structure
- Package `io_arb_pkg`:
  - state enum `io_arb_state_t` {IDLE, ISSUE, RESP}
  - offset constants `IO_PA`=3'd0, `IO_DDRA`=3'd1, `IO_PB`=3'd2, `IO_DDRB`=3'd3
  - `IO_UNMAPPED_RD`=8'hFF
- Sub-module `io_arb_rr`: combinational 2-way winner select from `req`, `last_grant` and `RR`, outputting a one-hot grant. Everything else lives in `io_arbiter`.

## Test plan
- **Single write:** req0 writes 8'hA5 to offset 1. Expect `io_enable` for one cycle with `io_addr`=1 and `io_wdata`=8'hA5, then `ack`=2'b01 one cycle later with `rerr`=0; an I/O model shows DDRA=8'hA5.
- **Read-back:** req1 reads offset 1 after the previous write. Expect `ack`=2'b10 with `rdata`=8'hA5 and `rerr`=0, 2 edges after the request.
- **Unmapped read:** req0 reads offset 5 (`io_oe` stays 0). Expect `ack`=2'b01, `rdata`=8'hFF, `rerr`=1.
- **Round-robin:** RR=1, both requesters hold `req` continuously for 4 transactions. Expect grants 0,1,0,1, strobes 3 cycles apart, and never two `ack` bits set at once.
- **Fixed priority:** RR=0, both requesters hold `req` for 3 transactions. Expect all three `ack`s to go to requester 0; requester 1 is granted on the first IDLE after req0 drops.
- **Reset mid-transaction:** assert `rst_n`=0 during ISSUE. Expect `io_enable`=0 and `ack`=0 immediately, all reset values as listed under Timing, and after release a pending req1 is granted normally.

Source files
------------

// File: rtl/io_arb_pkg.sv
// Shared types and constants for the 6530 I/O port arbiter.
// The I/O block decodes only offsets 0-3; reads of 4-7 return IO_UNMAPPED_RD.
package io_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } io_arb_state_t;

    localparam logic [2:0] IO_PA   = 3'd0;
    localparam logic [2:0] IO_DDRA = 3'd1;
    localparam logic [2:0] IO_PB   = 3'd2;
    localparam logic [2:0] IO_DDRB = 3'd3;

    localparam logic [7:0] IO_UNMAPPED_RD = 8'hFF;
    localparam logic [7:0] IO_WR_RDATA    = 8'h00;

endpackage

// File: rtl/io_arb_rr.sv
// Two-way winner select: round-robin on ties when RR=1, else requester 0 always wins.
// Purely combinational; the caller owns last_grant and only updates it at grant time.
module io_arb_rr #(
    parameter bit RR = 1'b1
) (
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = i_req;
        if (i_req == 2'b11) begin
            o_grant = (RR && !i_last_grant) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/io_arbiter.sv
// Arbitrates two requesters onto the 6530 I/O register port as single-cycle enable strobes.
// One access takes IDLE -> ISSUE -> RESP; read data is taken from the I/O block in RESP.
module io_arbiter
    import io_arb_pkg::*;
#(
    parameter bit RR = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [1:0] req_we_n,
    input  logic [2:0] req_addr0,
    input  logic [2:0] req_addr1,
    input  logic [7:0] req_wdata0,
    input  logic [7:0] req_wdata1,
    output logic [1:0] ack,
    output logic [7:0] rdata,
    output logic       rerr,
    output logic       io_enable,
    output logic       io_we_n,
    output logic [2:0] io_addr,
    output logic [7:0] io_wdata,
    input  logic [7:0] io_rdata,
    input  logic       io_oe
);

    io_arb_state_t r_state;
    logic          r_grant;
    logic          r_last_grant;
    logic          r_io_enable;
    logic          r_io_we_n;
    logic [2:0]    r_io_addr;
    logic [7:0]    r_io_wdata;

    logic [1:0]    w_grant_oh;
    logic          w_grant_idx;
    logic          w_start;

    io_arb_rr #(.RR(RR)) u_arb_rr (
        .i_req        (req),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant_oh)
    );

    assign w_start     = (r_state == IDLE) && (req != 2'b00);
    assign w_grant_idx = w_grant_oh[1];

    // The io_* registers double as the command registers, so they are loaded at grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_io_enable  <= 1'b0;
            r_io_we_n    <= 1'b1;
            r_io_addr    <= 3'd0;
            r_io_wdata   <= 8'h00;
        end else begin
            r_io_enable <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state      <= ISSUE;
                        r_io_enable  <= 1'b1;
                        r_grant      <= w_grant_idx;
                        r_last_grant <= w_grant_idx;
                        r_io_we_n    <= req_we_n[w_grant_idx];
                        r_io_addr    <= w_grant_idx ? req_addr1 : req_addr0;
                        r_io_wdata   <= w_grant_idx ? req_wdata1 : req_wdata0;
                    end
                end
                ISSUE:   r_state <= RESP;
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // io_rdata/io_oe are registered by the I/O block at the end of ISSUE, so valid in RESP.
    always_comb begin
        ack   = 2'b00;
        rdata = 8'h00;
        rerr  = 1'b0;
        if (r_state == RESP) begin
            ack = r_grant ? 2'b10 : 2'b01;
            if (!r_io_we_n) begin
                rdata = IO_WR_RDATA;
            end else if (io_oe) begin
                rdata = io_rdata;
            end else begin
                rdata = IO_UNMAPPED_RD;
                rerr  = 1'b1;
            end
        end
    end

    assign io_enable = r_io_enable;
    assign io_we_n   = r_io_we_n;
    assign io_addr   = r_io_addr;
    assign io_wdata  = r_io_wdata;

endmodule

// File: tb/tb_io_arbiter.sv
// Scoreboard bench for io_arbiter: instance 0 is round-robin, instance 1 fixed priority.
// Expected strobes and acks (with their cycle numbers) are queued by the stimulus and popped by a monitor.
module tb_io_arbiter;

    typedef struct {
        int         inst;
        int         cyc;
        logic [1:0] ack;
        logic [7:0] rdata;
        logic       rerr;
    } ack_exp_t;

    typedef struct {
        int         inst;
        int         cyc;
        logic       we_n;
        logic [2:0] addr;
        logic [7:0] wdata;
    } io_exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    logic [1:0][1:0] req_s;
    logic [1:0][1:0] we_s;
    logic [1:0][2:0] a0_s;
    logic [1:0][2:0] a1_s;
    logic [1:0][7:0] d0_s;
    logic [1:0][7:0] d1_s;
    logic [1:0][1:0] ack_s;
    logic [1:0][7:0] rdata_s;
    logic [1:0]      rerr_s;
    logic [1:0]      en_s;
    logic [1:0]      wen_s;
    logic [1:0][2:0] ia_s;
    logic [1:0][7:0] iw_s;
    logic [1:0][7:0] ird_s = '0;
    logic [1:0]      ioe_s = '0;
    logic [7:0]      mem [2][4] = '{default: 8'h00};
    logic [1:0]      prev_en = '0;

    ack_exp_t ack_q[$];
    io_exp_t  io_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        io_arbiter #(.RR(g == 0 ? 1'b1 : 1'b0)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .req        (req_s[g]),
            .req_we_n   (we_s[g]),
            .req_addr0  (a0_s[g]),
            .req_addr1  (a1_s[g]),
            .req_wdata0 (d0_s[g]),
            .req_wdata1 (d1_s[g]),
            .ack        (ack_s[g]),
            .rdata      (rdata_s[g]),
            .rerr       (rerr_s[g]),
            .io_enable  (en_s[g]),
            .io_we_n    (wen_s[g]),
            .io_addr    (ia_s[g]),
            .io_wdata   (iw_s[g]),
            .io_rdata   (ird_s[g]),
            .io_oe      (ioe_s[g])
        );
    end

    // Model of the 6530 I/O block: registered DO/OE, only offsets 0-3 decoded.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (en_s[i]) begin
                if (!wen_s[i] && ia_s[i] < 3'd4) mem[i][ia_s[i][1:0]] <= iw_s[i];
                ird_s[i] <= mem[i][ia_s[i][1:0]];
                ioe_s[i] <= wen_s[i] && (ia_s[i] < 3'd4);
            end else begin
                ioe_s[i] <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic exp_ack(input int inst, input int c, input logic [1:0] a,
                           input logic [7:0] d, input logic e);
        ack_exp_t x;
        x.inst = inst; x.cyc = c; x.ack = a; x.rdata = d; x.rerr = e;
        ack_q.push_back(x);
    endtask

    task automatic exp_io(input int inst, input int c, input logic w,
                          input logic [2:0] a, input logic [7:0] d);
        io_exp_t x;
        x.inst = inst; x.cyc = c; x.we_n = w; x.addr = a; x.wdata = d;
        io_q.push_back(x);
    endtask

    task automatic wait_ack(input int inst);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack_s[inst] == 2'b00 && n < 20);
        if (ack_s[inst] == 2'b00) check($sformatf("ack_timeout%0d", inst), 0, 1);
    endtask

    // Monitor: pops expectations whenever a strobe or ack is presented.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (en_s[i]) begin
                check($sformatf("strobe_gap%0d", i), {31'd0, prev_en[i]}, 0);
                if (io_q.size() == 0) begin
                    check($sformatf("unexpected_strobe%0d", i), 1, 0);
                end else begin
                    io_exp_t e;
                    e = io_q.pop_front();
                    check($sformatf("io_inst%0d", i), i, e.inst);
                    check($sformatf("io_cyc%0d", i), cyc, e.cyc);
                    check($sformatf("io_we_n%0d", i), {31'd0, wen_s[i]}, {31'd0, e.we_n});
                    check($sformatf("io_addr%0d", i), {29'd0, ia_s[i]}, {29'd0, e.addr});
                    check($sformatf("io_wdata%0d", i), {24'd0, iw_s[i]}, {24'd0, e.wdata});
                end
            end
            if (ack_s[i] != 2'b00) begin
                if (ack_q.size() == 0) begin
                    check($sformatf("unexpected_ack%0d", i), {30'd0, ack_s[i]}, 0);
                end else begin
                    ack_exp_t e;
                    e = ack_q.pop_front();
                    check($sformatf("ack_inst%0d", i), i, e.inst);
                    check($sformatf("ack_cyc%0d", i), cyc, e.cyc);
                    check($sformatf("ack%0d", i), {30'd0, ack_s[i]}, {30'd0, e.ack});
                    check($sformatf("rdata%0d", i), {24'd0, rdata_s[i]}, {24'd0, e.rdata});
                    check($sformatf("rerr%0d", i), {31'd0, rerr_s[i]}, {31'd0, e.rerr});
                end
            end
        end
        prev_en <= en_s;
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_en"},    {31'd0, en_s[0]},    0);
        check({tag, "_ack"},   {30'd0, ack_s[0]},   0);
        check({tag, "_rdata"}, {24'd0, rdata_s[0]}, 0);
        check({tag, "_rerr"},  {31'd0, rerr_s[0]},  0);
        check({tag, "_we_n"},  {31'd0, wen_s[0]},   1);
        check({tag, "_addr"},  {29'd0, ia_s[0]},    0);
        check({tag, "_wdata"}, {24'd0, iw_s[0]},    0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int c;
        rst_n = 1'b0;
        req_s = '0;
        we_s  = '1;
        a0_s  = '0;
        a1_s  = '0;
        d0_s  = '0;
        d1_s  = '0;
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        check("por_en1", {31'd0, en_s[1]}, 0);

        // Single write, granted on the first edge after reset release.
        rst_n = 1'b1;
        c = cyc;
        exp_io(0, c + 1, 1'b0, 3'd1, 8'hA5);
        exp_ack(0, c + 2, 2'b01, 8'h00, 1'b0);
        we_s[0][0] = 1'b0; a0_s[0] = 3'd1; d0_s[0] = 8'hA5; req_s[0] = 2'b01;
        wait_ack(0);
        req_s[0] = 2'b00;
        check("ddra_model", {24'd0, mem[0][1]}, 32'hA5);
        @(negedge clk);

        // Read-back by requester 1.
        c = cyc;
        exp_io(0, c + 1, 1'b1, 3'd1, 8'h3C);
        exp_ack(0, c + 2, 2'b10, 8'hA5, 1'b0);
        we_s[0][1] = 1'b1; a1_s[0] = 3'd1; d1_s[0] = 8'h3C; req_s[0] = 2'b10;
        wait_ack(0);
        req_s[0] = 2'b00;
        @(negedge clk);

        // Unmapped read.
        c = cyc;
        exp_io(0, c + 1, 1'b1, 3'd5, 8'hA5);
        exp_ack(0, c + 2, 2'b01, 8'hFF, 1'b1);
        we_s[0][0] = 1'b1; a0_s[0] = 3'd5; req_s[0] = 2'b01;
        wait_ack(0);
        req_s[0] = 2'b00;
        @(negedge clk);

        // Unmapped write: still issued, acked with zero data.
        c = cyc;
        exp_io(0, c + 1, 1'b0, 3'd6, 8'h5A);
        exp_ack(0, c + 2, 2'b10, 8'h00, 1'b0);
        we_s[0][1] = 1'b0; a1_s[0] = 3'd6; d1_s[0] = 8'h5A; req_s[0] = 2'b10;
        wait_ack(0);
        req_s[0] = 2'b00;
        @(negedge clk);

        // Round-robin with both requesters held for four transactions.
        c = cyc;
        exp_io(0, c + 1,  1'b0, 3'd0, 8'h11); exp_ack(0, c + 2,  2'b01, 8'h00, 1'b0);
        exp_io(0, c + 4,  1'b0, 3'd2, 8'h22); exp_ack(0, c + 5,  2'b10, 8'h00, 1'b0);
        exp_io(0, c + 7,  1'b1, 3'd0, 8'h11); exp_ack(0, c + 8,  2'b01, 8'h11, 1'b0);
        exp_io(0, c + 10, 1'b1, 3'd2, 8'h22); exp_ack(0, c + 11, 2'b10, 8'h22, 1'b0);
        we_s[0] = 2'b00; a0_s[0] = 3'd0; d0_s[0] = 8'h11; a1_s[0] = 3'd2; d1_s[0] = 8'h22;
        req_s[0] = 2'b11;
        wait_ack(0); we_s[0][0] = 1'b1;
        wait_ack(0); we_s[0][1] = 1'b1;
        wait_ack(0); req_s[0][0] = 1'b0;
        wait_ack(0); req_s[0] = 2'b00;
        @(negedge clk);

        // Fixed priority: requester 1 waits until requester 0 drops.
        c = cyc;
        exp_io(1, c + 1,  1'b0, 3'd1, 8'h01); exp_ack(1, c + 2,  2'b01, 8'h00, 1'b0);
        exp_io(1, c + 4,  1'b0, 3'd1, 8'h02); exp_ack(1, c + 5,  2'b01, 8'h00, 1'b0);
        exp_io(1, c + 7,  1'b0, 3'd1, 8'h03); exp_ack(1, c + 8,  2'b01, 8'h00, 1'b0);
        exp_io(1, c + 10, 1'b0, 3'd3, 8'h99); exp_ack(1, c + 11, 2'b10, 8'h00, 1'b0);
        we_s[1] = 2'b00; a0_s[1] = 3'd1; d0_s[1] = 8'h01; a1_s[1] = 3'd3; d1_s[1] = 8'h99;
        req_s[1] = 2'b11;
        wait_ack(1); d0_s[1] = 8'h02;
        wait_ack(1); d0_s[1] = 8'h03;
        wait_ack(1); req_s[1][0] = 1'b0;
        wait_ack(1); req_s[1] = 2'b00;
        check("fp_ddra_model", {24'd0, mem[1][1]}, 32'h03);
        check("fp_ddrb_model", {24'd0, mem[1][3]}, 32'h99);
        @(negedge clk);

        // Reset during ISSUE aborts; pending requester 1 is served after release.
        we_s[0] = 2'b11; a0_s[0] = 3'd2; a1_s[0] = 3'd1;
        req_s[0] = 2'b11;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_vals("abort");
        req_s[0][0] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        c = cyc;
        exp_io(0, c + 1, 1'b1, 3'd1, 8'h22);
        exp_ack(0, c + 2, 2'b10, 8'hA5, 1'b0);
        wait_ack(0);
        req_s[0] = 2'b00;
        @(negedge clk);

        // First tie after reset goes to requester 0.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        c = cyc;
        exp_io(0, c + 1, 1'b1, 3'd1, 8'h11); exp_ack(0, c + 2, 2'b01, 8'hA5, 1'b0);
        exp_io(0, c + 4, 1'b1, 3'd5, 8'h22); exp_ack(0, c + 5, 2'b10, 8'hFF, 1'b1);
        we_s[0] = 2'b11; a0_s[0] = 3'd1; a1_s[0] = 3'd5;
        req_s[0] = 2'b11;
        wait_ack(0); req_s[0][0] = 1'b0;
        wait_ack(0); req_s[0] = 2'b00;
        repeat (3) @(negedge clk);

        check("io_queue_left", io_q.size(), 0);
        check("ack_queue_left", ack_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
